// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI mode-0 slave protocol engine.
// Imported by the bus interface and by every module of the engine.
package spi_slave_if_pkg;

  localparam int unsigned DataWidth = 8;

  localparam logic [DataWidth-1:0] CmdWrDefault = 8'h02;
  localparam logic [DataWidth-1:0] CmdRdDefault = 8'h03;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StWdata  = 3'd3,
    StRdata  = 3'd4,
    StIgnore = 3'd5
  } state_e;

  // Register addresses wrap 8'hFF -> 8'h00.
  function automatic logic [DataWidth-1:0] addr_inc(input logic [DataWidth-1:0] addr);
    return addr + DataWidth'(1);
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pad signals plus the register-bank port, bundled for the slave engine.
// The slave modport is the engine's view; master is the pads/bank side.
interface spi_slave_if_if;
  import spi_slave_if_pkg::*;

  logic                 spi_sclk;
  logic                 spi_cs_n;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 spi_miso_oe;
  logic                 reg_wr_en;
  logic [DataWidth-1:0] reg_datin;
  logic [DataWidth-1:0] reg_addr;
  logic [DataWidth-1:0] reg_out;
  logic                 frame_active;

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    input  reg_out,
    output spi_miso,
    output spi_miso_oe,
    output reg_wr_en,
    output reg_datin,
    output reg_addr,
    output frame_active
  );

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    output reg_out,
    input  spi_miso,
    input  spi_miso_oe,
    input  reg_wr_en,
    input  reg_datin,
    input  reg_addr,
    input  frame_active
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses
// on the synchronised level (one clk wide each).
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversamples the SPI pins, decodes cmd/addr/data bytes,
// drives the register bank write port and serialises its read data on MISO.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DataWidth-1:0] CMD_WR      = CmdWrDefault,
  parameter logic [DataWidth-1:0] CMD_RD      = CmdRdDefault
) (
  input logic           clk,
  input logic           rst_n,
  spi_slave_if_if.slave bus
);

  logic sclk_rise;
  logic sclk_fall;
  logic unused_sclk_level;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.spi_sclk),
    .level(unused_sclk_level),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // cs_n resets as "asserted" so a cs_n already low at reset release never
  // looks like a falling edge; a fresh high-then-low is needed to start.
  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.spi_cs_n),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e               state_q, state_d;
  logic                 wr_flag_q, wr_flag_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DataWidth-2:0] rx_shift_q, rx_shift_d;
  logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] datin_q, datin_d;
  logic                 wr_en_q, wr_en_d;
  logic                 frame_q, frame_d;
  logic                 oe_q;

  logic                 in_frame;
  logic                 sample;
  logic                 shift;
  logic                 byte_done;
  logic [DataWidth-1:0] rx_byte;

  assign in_frame  = (state_q != StIdle) && !cs_level;
  assign sample    = sclk_rise && in_frame;
  assign shift     = sclk_fall && in_frame;
  assign byte_done = sample && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, mosi_s};

  always_comb begin
    state_d    = state_q;
    wr_flag_d  = wr_flag_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    addr_d     = addr_q;
    datin_d    = datin_q;
    wr_en_d    = 1'b0;
    frame_d    = frame_q;

    // Address moves only once the write strobe has been seen by the bank.
    if (wr_en_q) begin
      addr_d = addr_inc(addr_q);
    end

    if (sample) begin
      rx_shift_d = rx_byte[DataWidth-2:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    if (cs_rise) begin
      state_d   = StIdle;
      frame_d   = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            frame_d   = 1'b1;
          end
        end
        StCmd: begin
          if (byte_done) begin
            if (rx_byte == CMD_WR) begin
              state_d   = StAddr;
              wr_flag_d = 1'b1;
            end else if (rx_byte == CMD_RD) begin
              state_d   = StAddr;
              wr_flag_d = 1'b0;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddr: begin
          if (byte_done) begin
            addr_d  = rx_byte;
            state_d = wr_flag_q ? StWdata : StRdata;
          end
        end
        StWdata: begin
          if (byte_done) begin
            datin_d = rx_byte;
            wr_en_d = 1'b1;
          end
        end
        StRdata: begin
          // Bumped early so the registered bank data is ready by the next fall.
          if (byte_done) begin
            addr_d = addr_inc(addr_q);
          end
        end
        StIgnore: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    if (state_q != StRdata) begin
      tx_shift_d = '0;
    end else if (shift) begin
      tx_shift_d = (bit_cnt_q == 3'd0) ? bus.reg_out : {tx_shift_q[DataWidth-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_flag_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      addr_q     <= '0;
      datin_q    <= '0;
      wr_en_q    <= 1'b0;
      frame_q    <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_flag_q  <= wr_flag_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      addr_q     <= addr_d;
      datin_q    <= datin_d;
      wr_en_q    <= wr_en_d;
      frame_q    <= frame_d;
      oe_q       <= ~cs_level;
    end
  end

  assign bus.spi_miso     = tx_shift_q[DataWidth-1];
  assign bus.spi_miso_oe  = oe_q;
  assign bus.reg_wr_en    = wr_en_q;
  assign bus.reg_datin    = datin_q;
  assign bus.reg_addr     = addr_q;
  assign bus.frame_active = frame_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a small register-bank model plus an SPI
// master driving framed transfers, with immediate-assertion checks.
module tb_spi_slave_if;
  import spi_slave_if_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Bank model: 00..02 read-only ID bytes, 03 resets to 34, registered read.
  logic [7:0]  mem [256];
  logic        bank_ready = 1'b0;
  logic [15:0] wr_log [$];

  always @(posedge clk) begin
    if (!bank_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0]     <= 8'h49;
      mem[1]     <= 8'h45;
      mem[2]     <= 8'h46;
      mem[3]     <= 8'h34;
      bank_ready <= 1'b1;
    end else begin
      bus.reg_out <= mem[bus.reg_addr];
      if (bus.reg_wr_en) begin
        wr_log.push_back({bus.reg_addr, bus.reg_datin});
        if (bus.reg_addr > 8'h02) mem[bus.reg_addr] <= bus.reg_datin;
      end
    end
  end

  function automatic logic [15:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 16'hxxxx;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0: MOSI set while SCLK low, both sides sample on the rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      #80;
      rx[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      #80;
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    bus.spi_cs_n = 1'b1;
    #80;
  endtask

  logic [7:0] rx;
  logic [7:0] rx_or;
  logic [7:0] id_exp [3];

  initial begin
    id_exp[0] = 8'h49;
    id_exp[1] = 8'h45;
    id_exp[2] = 8'h46;
    rst_n        = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    #20;
    check("rst_miso", 16'(bus.spi_miso), 16'h0);
    check("rst_oe", 16'(bus.spi_miso_oe), 16'h0);
    check("rst_wr_en", 16'(bus.reg_wr_en), 16'h0);
    check("rst_datin", 16'(bus.reg_datin), 16'h0);
    check("rst_addr", 16'(bus.reg_addr), 16'h0);
    check("rst_frame", 16'(bus.frame_active), 16'h0);
    check("rst_state", 16'(dut.state_q), 16'(StIdle));
    #20;
    rst_n = 1'b1;
    #80;

    // Read ID: 03 00 then three data bytes.
    cs_low();
    check("id_frame_on", 16'(bus.frame_active), 16'h1);
    check("id_oe_on", 16'(bus.spi_miso_oe), 16'h1);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("id_addr0", 16'(bus.reg_addr), 16'h00);
    for (int i = 0; i < 3; i++) begin
      spi_xfer(8'h00, 8, rx);
      check("id_miso", 16'(rx), 16'(id_exp[i]));
      check("id_addr", 16'(bus.reg_addr), 16'(i + 1));
    end
    cs_high();
    check("id_frame_off", 16'(bus.frame_active), 16'h0);
    check("id_oe_off", 16'(bus.spi_miso_oe), 16'h0);
    check("id_no_write", 16'(wr_log.size()), 16'd0);

    // Abort: write frame cut after 5 data bits.
    cs_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hAB, 5, rx);
    cs_high();
    check("abort_no_write", 16'(wr_log.size()), 16'd0);
    check("abort_state", 16'(dut.state_q), 16'(StIdle));
    check("abort_frame", 16'(bus.frame_active), 16'h0);
    cs_low();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h00, 8, rx);
    cs_high();
    check("abort_readback", 16'(rx), 16'h34);

    // Write two bytes then read them back.
    cs_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hAB, 8, rx);
    spi_xfer(8'hCD, 8, rx);
    cs_high();
    check("wr_count", 16'(wr_log.size()), 16'd2);
    check("wr_0", log_at(0), 16'h03AB);
    check("wr_1", log_at(1), 16'h04CD);
    cs_low();
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h00, 8, rx);
    check("rb_0", 16'(rx), 16'hAB);
    spi_xfer(8'h00, 8, rx);
    check("rb_1", 16'(rx), 16'hCD);
    cs_high();

    // Address wrap FF -> 00.
    cs_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'hFF, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    cs_high();
    check("wrap_count", 16'(wr_log.size()), 16'd4);
    check("wrap_0", log_at(2), 16'hFF11);
    check("wrap_1", log_at(3), 16'h0022);
    check("wrap_addr", 16'(bus.reg_addr), 16'h01);

    // Unknown command: everything ignored.
    cs_low();
    rx_or = 8'h00;
    spi_xfer(8'h5A, 8, rx);
    rx_or |= rx;
    spi_xfer(8'h03, 8, rx);
    rx_or |= rx;
    spi_xfer(8'h77, 8, rx);
    rx_or |= rx;
    check("bad_state", 16'(dut.state_q), 16'(StIgnore));
    check("bad_frame_on", 16'(bus.frame_active), 16'h1);
    cs_high();
    check("bad_miso", 16'(rx_or), 16'h00);
    check("bad_no_write", 16'(wr_log.size()), 16'd4);
    check("bad_frame_off", 16'(bus.frame_active), 16'h0);

    // Reset in the middle of a data byte, cs_n held low throughout.
    cs_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h10, 8, rx);
    spi_xfer(8'h55, 4, rx);
    rst_n = 1'b0;
    #20;
    check("mid_rst_addr", 16'(bus.reg_addr), 16'h00);
    check("mid_rst_datin", 16'(bus.reg_datin), 16'h00);
    check("mid_rst_wr_en", 16'(bus.reg_wr_en), 16'h0);
    check("mid_rst_frame", 16'(bus.frame_active), 16'h0);
    check("mid_rst_miso", 16'(bus.spi_miso), 16'h0);
    check("mid_rst_oe", 16'(bus.spi_miso_oe), 16'h0);
    rst_n = 1'b1;
    #20;
    spi_xfer(8'h55, 4, rx);
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h10, 8, rx);
    spi_xfer(8'h55, 8, rx);
    check("post_rst_no_write", 16'(wr_log.size()), 16'd4);
    check("post_rst_frame", 16'(bus.frame_active), 16'h0);
    check("post_rst_state", 16'(dut.state_q), 16'(StIdle));
    check("post_rst_addr", 16'(bus.reg_addr), 16'h00);
    cs_high();
    cs_low();
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h10, 8, rx);
    spi_xfer(8'h55, 8, rx);
    cs_high();
    check("recover_count", 16'(wr_log.size()), 16'd5);
    check("recover_wr", log_at(4), 16'h1055);
    check("recover_addr", 16'(bus.reg_addr), 16'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
